// File: rtl/renas_clk_rst_pkg.sv
// Shared types and constants for the RENAS clock-enable / reset sequencer.
package renas_clk_rst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REL_MEM,
    ST_REL_L2,
    ST_REL_L1,
    ST_RUN,
    ST_HOLD
  } rst_state_e;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_L2_DIV      = 2;
  localparam int DEF_MEM_DIV     = 3;
  localparam int DEF_STAGGER_CYC = 4;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/renas_rst_sync.sv
// Reset synchronizer: asserts asynchronously, deasserts after SYNC_STAGES clock edges.
module renas_rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic rst_sync_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/renas_clk_rst_ctrl.sv
// Staggered reset release (mem, l2, l1, core) with divided clock-enable strobes
// and a software warm-reset path; every output comes straight from a flop.
module renas_clk_rst_ctrl
  import renas_clk_rst_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int L2_DIV      = DEF_L2_DIV,
  parameter int MEM_DIV     = DEF_MEM_DIV,
  parameter int STAGGER_CYC = DEF_STAGGER_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_rst_req,
  output logic mem_rst_n,
  output logic l2_rst_n,
  output logic l1_rst_n,
  output logic core_rst_n,
  output logic l1_en,
  output logic l2_en,
  output logic mem_en,
  output logic ready,
  output logic rst_cause
);

  localparam int STG_W = cnt_width(STAGGER_CYC);
  localparam int L2_W  = cnt_width(L2_DIV);
  localparam int MEM_W = cnt_width(MEM_DIV);

  localparam logic [STG_W-1:0] STG_LAST = STG_W'(STAGGER_CYC - 1);
  localparam logic [L2_W-1:0]  L2_LAST  = L2_W'(L2_DIV - 1);
  localparam logic [MEM_W-1:0] MEM_LAST = MEM_W'(MEM_DIV - 1);

  logic rst_sync;

  renas_rst_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .rst_sync_o(rst_sync)
  );

  rst_state_e       state_q, state_d;
  logic [STG_W-1:0] stg_q, stg_d;
  logic [L2_W-1:0]  l2_cnt_q, l2_cnt_d;
  logic [MEM_W-1:0] mem_cnt_q, mem_cnt_d;
  logic             mem_rst_q, l2_rst_q, l1_rst_q, core_rst_q;
  logic             mem_rst_d, l2_rst_d, l1_rst_d, core_rst_d;
  logic             l1_en_q, l2_en_q, mem_en_q, cause_q;
  logic             l1_en_d, l2_en_d, mem_en_d, cause_d;
  logic             active_d, restart_d, stg_done;

  always_comb begin
    state_d  = state_q;
    stg_d    = '0;
    cause_d  = cause_q;
    stg_done = (stg_q == STG_LAST);
    case (state_q)
      ST_IDLE: begin
        if (rst_sync) state_d = ST_REL_MEM;
      end
      ST_REL_MEM: begin
        stg_d = stg_q + STG_W'(1);
        if (stg_done) begin
          state_d = ST_REL_L2;
          stg_d   = '0;
        end
      end
      ST_REL_L2: begin
        stg_d = stg_q + STG_W'(1);
        if (stg_done) begin
          state_d = ST_REL_L1;
          stg_d   = '0;
        end
      end
      ST_REL_L1: begin
        stg_d = stg_q + STG_W'(1);
        if (stg_done) begin
          state_d = ST_RUN;
          stg_d   = '0;
        end
      end
      ST_RUN: begin
        if (sw_rst_req) begin
          state_d = ST_HOLD;
          cause_d = 1'b1;
        end
      end
      ST_HOLD: begin
        stg_d = stg_q + STG_W'(1);
        if (stg_done) begin
          state_d = ST_REL_MEM;
          stg_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Both dividers restart together so the strobes stay phase-aligned.
    active_d  = !(state_d inside {ST_IDLE, ST_HOLD});
    restart_d = (state_d == ST_REL_MEM) && (state_q != ST_REL_MEM);

    if (!active_d || restart_d || (l2_cnt_q == L2_LAST)) l2_cnt_d = '0;
    else                                                 l2_cnt_d = l2_cnt_q + L2_W'(1);
    if (!active_d || restart_d || (mem_cnt_q == MEM_LAST)) mem_cnt_d = '0;
    else                                                   mem_cnt_d = mem_cnt_q + MEM_W'(1);

    l1_en_d    = active_d;
    l2_en_d    = active_d && (l2_cnt_d == L2_LAST);
    mem_en_d   = active_d && (mem_cnt_d == MEM_LAST);
    mem_rst_d  = state_d inside {ST_REL_MEM, ST_REL_L2, ST_REL_L1, ST_RUN};
    l2_rst_d   = state_d inside {ST_REL_L2, ST_REL_L1, ST_RUN};
    l1_rst_d   = state_d inside {ST_REL_L1, ST_RUN};
    core_rst_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      stg_q      <= '0;
      l2_cnt_q   <= '0;
      mem_cnt_q  <= '0;
      mem_rst_q  <= 1'b0;
      l2_rst_q   <= 1'b0;
      l1_rst_q   <= 1'b0;
      core_rst_q <= 1'b0;
      l1_en_q    <= 1'b0;
      l2_en_q    <= 1'b0;
      mem_en_q   <= 1'b0;
      cause_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      stg_q      <= stg_d;
      l2_cnt_q   <= l2_cnt_d;
      mem_cnt_q  <= mem_cnt_d;
      mem_rst_q  <= mem_rst_d;
      l2_rst_q   <= l2_rst_d;
      l1_rst_q   <= l1_rst_d;
      core_rst_q <= core_rst_d;
      l1_en_q    <= l1_en_d;
      l2_en_q    <= l2_en_d;
      mem_en_q   <= mem_en_d;
      cause_q    <= cause_d;
    end
  end

  assign mem_rst_n  = mem_rst_q;
  assign l2_rst_n   = l2_rst_q;
  assign l1_rst_n   = l1_rst_q;
  assign core_rst_n = core_rst_q;
  assign ready      = core_rst_q;
  assign l1_en      = l1_en_q;
  assign l2_en      = l2_en_q;
  assign mem_en     = mem_en_q;
  assign rst_cause  = cause_q;

endmodule
